// File: rtl/zap_ram_pkg.sv
// Shared types and helpers for the zap RAM family.
package zap_ram_pkg;

    typedef enum logic {RAM_CLEAR, RAM_RUN} ram_state_t;

    // Byte-granular select between freshly written and stored data.
    function automatic logic [7:0] ben_merge(input logic [7:0] new_byte,
                                             input logic [7:0] old_byte,
                                             input logic       ben);
        return ben ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/zap_ram_ben_core.sv
// Byte-enable, read-first 1R+1W storage array. No reset: contents are
// defined only by writes.
module zap_ram_ben_core #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int NB    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [NB-1:0]    wr_ben,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read samples the pre-write contents; forwarding is handled above.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_ben[k]) begin
                    mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/zap_ram_simple_ben.sv
// 1R+1W RAM wrapper: byte enables, byte-merged same-cycle forwarding,
// optional output register, post-reset clear sweep, read-valid flag.
module zap_ram_simple_ben
    import zap_ram_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               DEPTH          = 32,
    parameter int               PIPE           = 0,
    parameter int               CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] INIT_VAL       = '0,
    localparam int              AW             = $clog2(DEPTH),
    localparam int              NB             = WIDTH / 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wr_en,
    input  logic [NB-1:0]    i_wr_ben,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic             o_init_done
);

    localparam ram_state_t    RST_STATE = (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_RUN;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    ram_state_t       state_q, state_d;
    logic [AW-1:0]    clr_addr_q;
    logic             run;
    logic             rd_acc;
    logic             hazard;

    logic             core_wr_en;
    logic [NB-1:0]    core_wr_ben;
    logic [AW-1:0]    core_wr_addr;
    logic [WIDTH-1:0] core_wr_data;
    logic [WIDTH-1:0] core_rd_data;

    logic [NB-1:0]    fwd_ben_q;
    logic [WIDTH-1:0] fwd_data_q;
    logic             rd1_valid_q;
    logic [WIDTH-1:0] merged;

    assign run         = (state_q == RAM_RUN);
    assign rd_acc      = run & i_rd_en;
    assign hazard      = rd_acc & i_wr_en & (i_wr_addr == i_rd_addr);
    assign o_init_done = run;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RAM_CLEAR) begin
                clr_addr_q <= clr_addr_q + AW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RAM_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = RAM_RUN;
            RAM_RUN:   state_d = RAM_RUN;
            default:   state_d = RST_STATE;
        endcase
    end

    // The sweep owns the write port until the array is usable.
    always_comb begin
        core_wr_en   = 1'b0;
        core_wr_ben  = '0;
        core_wr_addr = '0;
        core_wr_data = '0;
        if (run) begin
            core_wr_en   = i_wr_en;
            core_wr_ben  = i_wr_ben;
            core_wr_addr = i_wr_addr;
            core_wr_data = i_wr_data;
        end else begin
            core_wr_en   = 1'b1;
            core_wr_ben  = '1;
            core_wr_addr = clr_addr_q;
            core_wr_data = INIT_VAL;
        end
    end

    zap_ram_ben_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .NB    (NB)
    ) u_core (
        .clk     (i_clk),
        .wr_en   (core_wr_en),
        .wr_ben  (core_wr_ben),
        .wr_addr (core_wr_addr),
        .wr_data (core_wr_data),
        .rd_en   (rd_acc),
        .rd_addr (i_rd_addr),
        .rd_data (core_rd_data)
    );

    // Same-cycle write bytes are captured alongside the read so the
    // read-first array can be patched at the output.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fwd_ben_q   <= '0;
            fwd_data_q  <= '0;
            rd1_valid_q <= 1'b0;
        end else begin
            rd1_valid_q <= rd_acc;
            if (rd_acc) begin
                fwd_ben_q  <= hazard ? i_wr_ben : '0;
                fwd_data_q <= i_wr_data;
            end
        end
    end

    for (genvar k = 0; k < NB; k++) begin : g_merge
        assign merged[8*k +: 8] = ben_merge(fwd_data_q[8*k +: 8],
                                            core_rd_data[8*k +: 8],
                                            fwd_ben_q[k]);
    end

    if (PIPE != 0) begin : g_pipe
        logic [WIDTH-1:0] out_q;
        logic             valid_q;

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd1_valid_q;
                if (rd1_valid_q) begin
                    out_q <= merged;
                end
            end
        end

        assign o_rd_data  = out_q;
        assign o_rd_valid = valid_q;
    end else begin : g_nopipe
        // Masks the unreset array output until the first accepted read.
        logic rd_seen_q;

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                rd_seen_q <= 1'b0;
            end else if (rd_acc) begin
                rd_seen_q <= 1'b1;
            end
        end

        assign o_rd_data  = rd_seen_q ? merged : '0;
        assign o_rd_valid = rd1_valid_q;
    end

endmodule

// File: doc/zap_ram_simple_ben.md
# zap_ram_simple_ben

Parametrised 1R + 1W block-RAM wrapper, successor to the single-cycle simple RAM. It adds per-byte write enables with byte-merged same-cycle write-to-read forwarding, and an optional output pipeline register. A reset-time clear sequencer sweeps the array to a known value, and a read-valid flag accompanies the data. It serves as the storage primitive for caches, TLBs and register files that need partial writes and guaranteed post-reset contents.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; must be a power of 2 and ≥ 2. AW = $clog2(DEPTH).
- PIPE, 0, 0 gives read latency 1; 1 adds an output register for read latency 2.
- CLEAR_ON_RESET, 1, 1 sweeps the array to INIT_VAL after reset; 0 skips the sweep.
- INIT_VAL, 0, WIDTH-bit word written to every location during the sweep.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_wr_en  in  1  write request.
- i_wr_ben  in  WIDTH/8  byte enables; bit k covers data[8k+7:8k].
- i_wr_addr  in  AW  write address.
- i_wr_data  in  WIDTH  write data.
- i_rd_en  in  1  read request.
- i_rd_addr  in  AW  read address.
- o_rd_data  out  WIDTH  read data.
- o_rd_valid  out  1  o_rd_data holds the result of an accepted read.
- o_init_done  out  1  high once the array is usable.

## Operation
- FSM states are CLEAR and RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- CLEAR behaviour:
  - The address counter starts at 0 and writes INIT_VAL with all bytes enabled, one word per cycle.
  - After writing DEPTH-1 the FSM moves to RUN. The sweep takes exactly DEPTH cycles.
  - User writes and reads are ignored: no array update and no o_rd_valid.
- RUN: o_init_done=1. An access is accepted when its enable is high on a clock edge.
- Write: only bytes with i_wr_ben[k]=1 are updated. A write with i_wr_ben=0 is a no-op.
- Read: returns the word at i_rd_addr as updated by any write accepted in the same cycle (write-first per byte).
  - The array is read-first, so the hazard (rd_en & wr_en & equal addresses & RUN) is registered together with i_wr_data and i_wr_ben.
  - At the output, byte k is taken from the buffered write data if its buffered enable is set, otherwise from the array.
- A write accepted in a cycle after the read was accepted is not visible to that read, including the PIPE=1 case.
- With no read accepted, o_rd_data holds its last value; hazard and buffer state update only on accepted reads.
- Writes and reads to different addresses are fully independent.
- Reset asserted mid-sweep or mid-read behaves as follows:
  - Outputs return to reset values and the sweep restarts from address 0.
  - Array contents are undefined until the sweep finishes.

## Timing
- Reset values: o_rd_data=0, o_rd_valid=0, o_init_done=0 (1 if CLEAR_ON_RESET=0), FSM=CLEAR (RUN), counter=0.
- With CLEAR_ON_RESET=1 and reset released before edge 0, o_init_done rises after edge DEPTH-1 and accesses are accepted from edge DEPTH.
- PIPE=0: a read accepted at edge t gives data and o_rd_valid=1 after edge t. o_rd_valid is low after an edge with no accepted read.
- PIPE=1: a read accepted at edge t gives data and o_rd_valid=1 after edge t+1. Back-to-back reads stream one per cycle.
- A write accepted at edge t is visible to any read accepted at edge t or later.

## Structure
- The shared package zap_ram_pkg holds:
  - the typedef enum logic {RAM_CLEAR, RAM_RUN} ram_state_t;
  - the function ben_merge(new, old, ben) used for the forwarding mux.
- Sub-module: reuse zap_ram_simple_nopipe-style storage as zap_ram_ben_core, a pure byte-enable read-first array with no reset. All steering, FSM and pipeline logic live in the top level.

## Test plan
- Reset with DEPTH=32, CLEAR_ON_RESET=1, INIT_VAL=32'hA5A5_A5A5, then read every address. o_init_done rises after 32 cycles and all reads return A5A5_A5A5.
- Write 32'h1122_3344 to addr 5 with ben=4'hF. Next cycle, write 32'hFFFF_FFFF with ben=4'b0101 while reading addr 5 in the same cycle. Read returns 32'h11FF_33FF.
- In the same cycle write addr 3 = 32'hDEAD_BEEF and read addr 4 (prior 32'h0). Read returns 0; a later read of addr 3 returns DEAD_BEEF.
- PIPE=1 back-to-back reads of addrs 0,1,2 (preloaded 10,11,12):
  - o_rd_valid is high on cycles t+2..t+4 and data is 10, 11, 12;
  - a write to addr 2 at cycle t+3 does not alter the 12.
- Idle cycles after a read: o_rd_data holds its value and o_rd_valid=0. A write with ben=0 leaves the location unchanged.
- Assert i_reset_n low midway through the sweep (counter=10). Outputs reset immediately, the sweep restarts at 0, and o_init_done rises DEPTH cycles after release.
